// File: rtl/timer_sched_if.sv
// timer_sched_if: bundle between client requesters and the shared-countdown
// scheduler.
//
// Handshake: a requester raises req[i] and holds it until gnt[i] is seen.
// gnt[i] is a single-cycle registered pulse. In that same cycle the scheduler
// has already captured dly[i]. done[i] is a single-cycle pulse that marks
// expiry of requester i's delay. cancel[i] aborts only a delay that i owns.
//
// Signals (client view):
//   tick      - count enable
//   req       - level request, one bit per requester
//   dly       - packed per-requester delays, slice i = dly[i*WIDTH +: WIDTH]
//   cancel    - abort request, honoured only for the current owner
//   gnt       - one-hot grant pulse
//   done      - one-hot expiry pulse
//   busy      - a delay is in flight (RUN or DONE)
//   owner     - current or last-granted requester index
//   o_cnt     - current count
//   dbg_state - raw scheduler state (0 IDLE, 1 RUN, 2 DONE)
interface timer_sched_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 10
);
  localparam int IDW = $clog2(N_REQ);

  logic                   tick;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] dly;
  logic [N_REQ-1:0]       cancel;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [IDW-1:0]         owner;
  logic [WIDTH-1:0]       o_cnt;
  logic [1:0]             dbg_state;

  modport master (
    output tick, req, dly, cancel,
    input  gnt, done, busy, owner, o_cnt, dbg_state
  );

  modport slave (
    input  tick, req, dly, cancel,
    output gnt, done, busy, owner, o_cnt, dbg_state
  );
endinterface

// File: rtl/timer_sched.sv
// timer_sched: one down-counter shared round-robin among N_REQ requesters.
// Only one delay is in flight at a time. Expiry pulses done[owner].
//
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - timer_sched_if.slave (tick/req/dly/cancel in;
//          gnt/done/busy/owner/o_cnt/dbg_state out)
//
// Every output is a register, or a decode of registers only. No request,
// tick or cancel input reaches an output combinationally.
module timer_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 10
) (
  input  logic         clk,
  input  logic         rst,
  timer_sched_if.slave bus
);
  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [WIDTH-1:0] win_dly;
  logic [N_REQ-1:0] win_oh;
  logic             own_cancel;
  logic [N_REQ-1:0] done_dec;

  // Round-robin pick. The first pass searches last+1 .. N_REQ-1. The second
  // pass wraps to 0 .. last. The first hit wins. The winner's delay slice is
  // captured in the same loop, so the delay is never indexed by a variable.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_dly   = '0;
    win_oh    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && bus.req[i] && (i > int'(last_q))) begin
        win_found = 1'b1;
        win_idx   = IDW'(i);
        win_dly   = bus.dly[i*WIDTH +: WIDTH];
        win_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && bus.req[i]) begin
        win_found = 1'b1;
        win_idx   = IDW'(i);
        win_dly   = bus.dly[i*WIDTH +: WIDTH];
        win_oh[i] = 1'b1;
      end
    end
  end

  // Only the owner's cancel bit matters. The done pulse is decoded from the
  // state and owner registers.
  always_comb begin
    own_cancel = 1'b0;
    done_dec   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == IDW'(i)) begin
        own_cancel  = bus.cancel[i];
        done_dec[i] = (state_q == S_DONE);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          owner_d = win_idx;
          gnt_d   = win_oh;
          cnt_d   = win_dly;
          // A zero delay skips RUN, so gnt and done land in the same cycle.
          state_d = (win_dly != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        // Cancel has priority over an expiring tick.
        if (own_cancel) begin
          cnt_d   = '0;
          last_d  = owner_q;
          state_d = S_IDLE;
        end else if (bus.tick) begin
          if (cnt_q > WIDTH'(1)) begin
            cnt_d = cnt_q - WIDTH'(1);
          end else begin
            cnt_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= IDW'(N_REQ - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_dec;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.owner     = owner_q;
  assign bus.o_cnt     = cnt_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: directed, table-driven bench for timer_sched.
// Each table row gives the inputs for one cycle and the outputs required
// after the next rising edge. Hand-written sequences follow for round-robin
// order and the maximum-width countdown.
module tb_timer_sched;
  localparam int N = 4;
  localparam int W = 10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  timer_sched_if #(.N_REQ(N), .WIDTH(W)) bus ();

  timer_sched #(.N_REQ(N), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string        tag;
    logic         rst;
    logic         tick;
    logic [3:0]   req;
    logic [3:0]   cancel;
    logic [39:0]  dly;
    logic [3:0]   e_gnt;
    logic [3:0]   e_done;
    logic         e_busy;
    logic [1:0]   e_owner;
    logic [9:0]   e_cnt;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];
  logic [1:0] exp_own_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic logic [39:0] dl(int a, int b, int c, int d);
    return {d[9:0], c[9:0], b[9:0], a[9:0]};
  endfunction

  function automatic vec_t mkv(string tag, int r, int t, int rq, int cx,
                               logic [39:0] d, int g, int dn, int b,
                               int o, int c);
    vec_t v;
    v.tag     = tag;
    v.rst     = r[0];
    v.tick    = t[0];
    v.req     = rq[3:0];
    v.cancel  = cx[3:0];
    v.dly     = d;
    v.e_gnt   = g[3:0];
    v.e_done  = dn[3:0];
    v.e_busy  = b[0];
    v.e_owner = o[1:0];
    v.e_cnt   = c[9:0];
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic r, logic t, logic [3:0] rq, logic [3:0] cx,
                       logic [39:0] d);
    rst        = r;
    bus.tick   = t;
    bus.req    = rq;
    bus.cancel = cx;
    bus.dly    = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(string name, logic [3:0] g, logic [3:0] dn,
                            logic b, logic [1:0] o, logic [9:0] c);
    chk({name, " gnt"},   32'(bus.gnt),   32'(g));
    chk({name, " done"},  32'(bus.done),  32'(dn));
    chk({name, " busy"},  32'(bus.busy),  32'(b));
    chk({name, " owner"}, 32'(bus.owner), 32'(o));
    chk({name, " o_cnt"}, 32'(bus.o_cnt), 32'(c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int run_cycles;
    int done_cnt;
    logic wrapped;
    logic [9:0] prev_cnt;
    logic [3:0] e;
    logic [1:0] eo;

    drive(1'b1, 1'b0, 4'h0, 4'h0, 40'h0);

    // Reset with inputs active, then a basic 3-tick delay for requester 0.
    vecs.push_back(mkv("rst0", 1, 1, 'hf, 'hf, dl(5,5,5,5), 0, 0, 0, 0, 0));
    vecs.push_back(mkv("rst1", 1, 0, 'ha, 'h5, dl(3,7,0,9), 0, 0, 0, 0, 0));
    vecs.push_back(mkv("g0",   0, 1, 'h1, 0, dl(3,0,0,0), 'h1, 0, 1, 0, 3));
    vecs.push_back(mkv("c2",   0, 1, 0,   0, dl(3,0,0,0), 0, 0, 1, 0, 2));
    vecs.push_back(mkv("c1",   0, 1, 0,   0, dl(3,0,0,0), 0, 0, 1, 0, 1));
    vecs.push_back(mkv("d0",   0, 1, 0,   0, dl(3,0,0,0), 0, 'h1, 1, 0, 0));
    vecs.push_back(mkv("i0",   0, 1, 0,   0, dl(3,0,0,0), 0, 0, 0, 0, 0));
    // Sparse tick on requester 2: the count holds between ticks.
    vecs.push_back(mkv("g2",   0, 0, 'h4, 0, dl(0,0,2,0), 'h4, 0, 1, 2, 2));
    vecs.push_back(mkv("h2a",  0, 0, 0,   0, dl(0,0,2,0), 0, 0, 1, 2, 2));
    vecs.push_back(mkv("t2a",  0, 1, 0,   0, dl(0,0,2,0), 0, 0, 1, 2, 1));
    vecs.push_back(mkv("h2b",  0, 0, 0,   0, dl(0,0,2,0), 0, 0, 1, 2, 1));
    vecs.push_back(mkv("h2c",  0, 0, 0,   0, dl(0,0,2,0), 0, 0, 1, 2, 1));
    vecs.push_back(mkv("t2b",  0, 1, 0,   0, dl(0,0,2,0), 0, 'h4, 1, 2, 0));
    vecs.push_back(mkv("i2",   0, 0, 0,   0, dl(0,0,2,0), 0, 0, 0, 2, 0));
    // Zero delay: gnt and done in the same cycle.
    vecs.push_back(mkv("z1",   0, 1, 'h2, 0, dl(0,0,0,0), 'h2, 'h2, 1, 1, 0));
    vecs.push_back(mkv("i1",   0, 1, 0,   0, dl(0,0,0,0), 0, 0, 0, 1, 0));
    // Owner 3: a non-owner cancel is ignored, then the owner cancels at count 2.
    vecs.push_back(mkv("g3",   0, 1, 'h8, 0,   dl(0,0,0,5), 'h8, 0, 1, 3, 5));
    vecs.push_back(mkv("nc",   0, 1, 0,   'h1, dl(0,0,0,5), 0, 0, 1, 3, 4));
    vecs.push_back(mkv("t3",   0, 1, 0,   0,   dl(0,0,0,5), 0, 0, 1, 3, 3));
    vecs.push_back(mkv("t3b",  0, 1, 0,   0,   dl(0,0,0,5), 0, 0, 1, 3, 2));
    vecs.push_back(mkv("cx3",  0, 1, 0,   'h8, dl(0,0,0,5), 0, 0, 0, 3, 0));
    vecs.push_back(mkv("i3",   0, 1, 0,   0,   dl(0,0,0,5), 0, 0, 0, 3, 0));
    // Cancel in the same cycle as the expiring tick: no done.
    vecs.push_back(mkv("g0b",  0, 1, 'h1, 0,   dl(1,0,0,0), 'h1, 0, 1, 0, 1));
    vecs.push_back(mkv("cve",  0, 1, 0,   'h1, dl(1,0,0,0), 0, 0, 0, 0, 0));
    vecs.push_back(mkv("i0b",  0, 1, 0,   0,   dl(1,0,0,0), 0, 0, 0, 0, 0));
    // Mid-run reset; a dly change after grant is ignored; priority returns to 0.
    vecs.push_back(mkv("g2b",  0, 1, 'h4, 0, dl(0,0,6,0), 'h4, 0, 1, 2, 6));
    vecs.push_back(mkv("t5",   0, 1, 0,   0, dl(0,0,9,0), 0, 0, 1, 2, 5));
    vecs.push_back(mkv("t4",   0, 1, 0,   0, dl(0,0,9,0), 0, 0, 1, 2, 4));
    vecs.push_back(mkv("rr",   1, 1, 'h4, 0, dl(0,0,9,0), 0, 0, 0, 0, 0));
    vecs.push_back(mkv("gp",   0, 1, 'hf, 0, dl(1,1,1,1), 'h1, 0, 1, 0, 1));
    // The req seen during DONE is ignored, so it is granted two cycles later.
    vecs.push_back(mkv("dp",   0, 1, 0,   0, dl(1,1,1,1), 0, 'h1, 1, 0, 0));
    vecs.push_back(mkv("dd",   0, 1, 'h2, 0, dl(1,1,1,1), 0, 0, 0, 0, 0));
    vecs.push_back(mkv("gn",   0, 1, 'h2, 0, dl(0,1,0,0), 'h2, 0, 1, 1, 1));
    vecs.push_back(mkv("en",   0, 1, 0,   0, dl(0,1,0,0), 0, 'h2, 1, 1, 0));
    vecs.push_back(mkv("fin",  0, 1, 0,   0, dl(0,1,0,0), 0, 0, 0, 1, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].tick, vecs[i].req, vecs[i].cancel, vecs[i].dly);
      step();
      check_outs($sformatf("vec[%0d] %s", i, vecs[i].tag), vecs[i].e_gnt,
                 vecs[i].e_done, vecs[i].e_busy, vecs[i].e_owner, vecs[i].e_cnt);
    end

    // Round-robin with all requests held: order 0,1,2,3,0 with 3-cycle spacing.
    drive(1'b1, 1'b0, 4'h0, 4'h0, 40'h0);
    step();
    check_outs("rr reset", 4'h0, 4'h0, 1'b0, 2'd0, 10'd0);
    for (int g = 0; g < 5; g++) begin
      exp_q.push_back(4'h1 << (g % 4));
      exp_own_q.push_back(2'(g % 4));
    end
    drive(1'b0, 1'b1, 4'hf, 4'h0, dl(1,1,1,1));
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      eo = exp_own_q.pop_front();
      step();
      check_outs($sformatf("rr gnt%0d", eo), e, 4'h0, 1'b1, eo, 10'd1);
      step();
      check_outs($sformatf("rr done%0d", eo), 4'h0, e, 1'b1, eo, 10'd0);
      step();
      check_outs($sformatf("rr gap%0d", eo), 4'h0, 4'h0, 1'b0, eo, 10'd0);
    end

    // Maximum width delay: 1023 RUN cycles, one done, no wrap.
    drive(1'b1, 1'b0, 4'h0, 4'h0, 40'h0);
    step();
    drive(1'b0, 1'b1, 4'h1, 4'h0, dl(1023,0,0,0));
    step();
    chk("max gnt", 32'(bus.gnt), 32'h1);
    chk("max o_cnt", 32'(bus.o_cnt), 32'd1023);
    bus.req    = 4'h0;
    run_cycles = (bus.busy && bus.done == 4'h0) ? 1 : 0;
    done_cnt   = 0;
    wrapped    = 1'b0;
    prev_cnt   = bus.o_cnt;
    for (int k = 1; k < 1030; k++) begin
      step();
      if (bus.done != 4'h0) begin
        done_cnt++;
        chk("max done o_cnt", 32'(bus.o_cnt), 32'd0);
        chk("max done bit", 32'(bus.done), 32'h1);
      end else if (bus.busy) begin
        run_cycles++;
      end
      if (bus.o_cnt > prev_cnt) wrapped = 1'b1;
      prev_cnt = bus.o_cnt;
    end
    chk("max run cycles", 32'(run_cycles), 32'd1023);
    chk("max done count", 32'(done_cnt), 32'd1);
    chk("max no wrap", 32'(wrapped), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
